src_poly_linear_mc: RTL

Multi-channel asynchronous sample-rate converter using linear interpolation between adjacent input frames. The step ratio is a programmable fixed-point value, so a single instance covers upsampling, downsampling and 1:1 operation. It sits between the PCM receive path and the audio DSP/output FIFO. It generalises the single-channel converter with runtime-programmable ratio, valid/ready handshakes on both sides, parametrised width, channels and depth, and a bypass mode.

---
 rtl/src_poly_linear_mc.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/src_poly_linear_mc.sv
// -----------------------------------------------------------------------------
// src_poly_linear_mc
//   Multi-channel sample-rate converter. Input frames are buffered in a
//   show-ahead FIFO. A small FSM keeps the two most recent frames (x0, x1) and
//   emits x0 + (x1 - x0) * frac for every output frame. frac advances by a
//   programmable Q4.PHASE_W step (Fin/Fout) at each output handshake. The
//   integer carry of that step tells how many input frames to skip. A latched
//   bypass mode forwards the input stream combinationally.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   enable          0 = flush and idle; the 0->1 edge latches bypass
//   bypass          pass-through select (taken on the enable rise)
//   ratio           unsigned Q4.PHASE_W step, sampled at each output handshake
//   s_valid/s_ready/s_data   input frame stream (channel 0 in the LSBs)
//   m_valid/m_ready/m_data   output frame stream
//   fifo_level      input FIFO occupancy
//   starve          ADVANCE is waiting on an empty FIFO
// -----------------------------------------------------------------------------
module src_poly_linear_mc #(
  parameter int unsigned CH         = 2,
  parameter int unsigned DW         = 24,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned PHASE_W    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          bypass,
  input  logic [PHASE_W+3:0]            ratio,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [CH*DW-1:0]              s_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [CH*DW-1:0]              m_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          starve
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned FW = CH * DW;
  localparam int unsigned PW = DW + PHASE_W + 2;

  typedef enum logic [2:0] {
    IDLE,
    PRIME0,
    PRIME1,
    CALC,
    OUT,
    ADVANCE
  } state_t;

  state_t               state_q;
  logic                 en_q;
  logic                 bypass_q;
  logic [FW-1:0]        x0_q;
  logic [FW-1:0]        x1_q;
  logic [FW-1:0]        m_data_q;
  logic [PHASE_W-1:0]   frac_q;
  logic [3:0]           skip_q;

  logic [FW-1:0]        mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q;
  logic [AW-1:0]        rd_ptr_q;
  logic [AW:0]          count_q;

  logic                 byp_eff;
  logic                 byp_mode;
  logic                 src_en;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 src_ready;
  logic                 push;
  logic                 pop;
  logic [FW-1:0]        head;
  logic [FW-1:0]        y;

  logic [PHASE_W+3:0]   ratio_eff;
  logic [PHASE_W+3:0]   acc;
  logic [PHASE_W-1:0]   frac_d;
  logic [3:0]           skip_d;

  // On the enable rising edge the latch has not been loaded yet, so the live
  // bypass input is used for that first cycle; afterwards the latched copy.
  assign byp_eff  = en_q ? bypass_q : bypass;
  assign byp_mode = enable & byp_eff;
  assign src_en   = enable & ~byp_eff;

  // ---------------------------------------------------------------------------
  // Input FIFO (show-ahead: head is the entry at rd_ptr)
  // ---------------------------------------------------------------------------
  assign fifo_full  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];
  assign src_ready  = src_en & ~fifo_full;
  assign push       = s_valid & src_ready;
  assign pop        = src_en & ~fifo_empty &
                      ((state_q == PRIME0) || (state_q == PRIME1) ||
                       (state_q == ADVANCE));

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (!enable) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  // ---------------------------------------------------------------------------
  // Enable edge detect and bypass latch
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q     <= 1'b0;
      bypass_q <= 1'b0;
    end else begin
      en_q <= enable;
      if (!enable) begin
        bypass_q <= 1'b0;
      end else if (!en_q) begin
        bypass_q <= bypass;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Interpolator, all channels in parallel.
  // p = (x1 - x0) * frac is exact in PW bits; taking bits [PW-1:PHASE_W] is an
  // arithmetic shift, i.e. floor. The sum stays between x0 and x1, so the low
  // DW bits are the exact result.
  // ---------------------------------------------------------------------------
  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [DW-1:0]        a0;
    logic [DW-1:0]        a1;
    logic signed [DW:0]   d;
    logic signed [PW-1:0] d_x;
    logic signed [PW-1:0] f_x;
    logic signed [PW-1:0] p;
    logic [DW+1:0]        q_s;
    logic [DW+1:0]        sum;
    logic                 unused_bits;

    assign a0          = x0_q[c*DW +: DW];
    assign a1          = x1_q[c*DW +: DW];
    assign d           = $signed({a1[DW-1], a1}) - $signed({a0[DW-1], a0});
    assign d_x         = {{(PHASE_W+1){d[DW]}}, d};
    assign f_x         = {{(DW+2){1'b0}}, frac_q};
    assign p           = d_x * f_x;
    assign q_s         = p[PW-1:PHASE_W];
    assign sum         = {{2{a0[DW-1]}}, a0} + q_s;
    assign y[c*DW +: DW] = sum[DW-1:0];
    assign unused_bits = ^{p[PHASE_W-1:0], sum[DW+1:DW]};
  end

  // ---------------------------------------------------------------------------
  // Phase accumulator: a zero ratio is promoted to one LSB so the phase always
  // moves forward.
  // ---------------------------------------------------------------------------
  assign ratio_eff = (ratio == '0) ? {{(PHASE_W+3){1'b0}}, 1'b1} : ratio;
  assign acc       = {4'b0000, frac_q} + ratio_eff;
  assign frac_d    = acc[PHASE_W-1:0];
  assign skip_d    = acc[PHASE_W+3:PHASE_W];

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      x0_q     <= '0;
      x1_q     <= '0;
      m_data_q <= '0;
      frac_q   <= '0;
      skip_q   <= '0;
    end else if (!enable) begin
      state_q  <= IDLE;
      x0_q     <= '0;
      x1_q     <= '0;
      m_data_q <= '0;
      frac_q   <= '0;
      skip_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!byp_eff) begin
            state_q <= PRIME0;
          end
        end
        PRIME0: begin
          if (!fifo_empty) begin
            x1_q    <= head;
            state_q <= PRIME1;
          end
        end
        PRIME1: begin
          if (!fifo_empty) begin
            x0_q    <= x1_q;
            x1_q    <= head;
            frac_q  <= '0;
            state_q <= CALC;
          end
        end
        CALC: begin
          m_data_q <= y;
          state_q  <= OUT;
        end
        OUT: begin
          if (m_ready) begin
            frac_q  <= frac_d;
            skip_q  <= skip_d;
            state_q <= (skip_d == 4'd0) ? CALC : ADVANCE;
          end
        end
        ADVANCE: begin
          if (!fifo_empty) begin
            x0_q   <= x1_q;
            x1_q   <= head;
            skip_q <= skip_q - 4'd1;
            if (skip_q == 4'd1) begin
              state_q <= CALC;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign s_ready    = byp_mode ? m_ready : src_ready;
  assign m_valid    = byp_mode ? s_valid : (enable & (state_q == OUT));
  assign m_data     = byp_mode ? s_data : m_data_q;
  assign fifo_level = count_q;
  assign starve     = enable & (state_q == ADVANCE) & fifo_empty;

endmodule
